// File: rtl/byte_packer_pkg.sv
// Shared definitions for byte_packer: FSM state encoding, word geometry
// and the checksum accumulate helper.
package byte_packer_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef logic [0:0] state_t;
  localparam state_t COLLECT = 1'b0;
  localparam state_t HOLD    = 1'b1;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of bytes into 32-bit words with byte enables and flush.
// Optional XOR checksum output chk_o is enabled by BYTE_PACKER_CHECKSUM_EN.
module byte_packer
  import byte_packer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [7:0]  data_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o
`ifdef BYTE_PACKER_CHECKSUM_EN
  ,
  output logic [7:0]  chk_o
`endif
);

  localparam int unsigned DATA_W = WORD_BYTES * 8;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [1:0]          cnt_r;
  logic [1:0]          cnt_nxt_s;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   data_nxt_s;
  logic [WORD_BYTES-1:0] be_r;
  logic [WORD_BYTES-1:0] be_nxt_s;
  logic                accept_s;
  logic                close_s;
`ifdef BYTE_PACKER_CHECKSUM_EN
  logic [7:0]          chk_r;
  logic [7:0]          chk_nxt_s;
`endif

  assign ready_o  = (state_r == COLLECT);
  assign valid_o  = (state_r == HOLD);
  assign accept_s = valid_i & ready_o;
  // A word closes when the last lane fills or a flush finds something to emit.
  assign close_s  = (accept_s && (cnt_r == 2'd3)) ||
                    (flush_i && ((cnt_r != 2'd0) || accept_s));

  // Next-state, lane fill and clear-on-handoff logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    be_nxt_s    = be_r;
`ifdef BYTE_PACKER_CHECKSUM_EN
    chk_nxt_s   = chk_r;
`endif
    case (state_r)
      COLLECT: begin
        if (accept_s) begin
          case (cnt_r)
            2'd0:    data_nxt_s[7:0]   = data_i;
            2'd1:    data_nxt_s[15:8]  = data_i;
            2'd2:    data_nxt_s[23:16] = data_i;
            2'd3:    data_nxt_s[31:24] = data_i;
            default: data_nxt_s        = data_r;
          endcase
          be_nxt_s  = be_r | (4'b0001 << cnt_r);
          cnt_nxt_s = cnt_r + 2'd1;
`ifdef BYTE_PACKER_CHECKSUM_EN
          chk_nxt_s = chk_update(chk_r, data_i);
`endif
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if (close_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      HOLD: begin
        if (ready_i) begin
          state_nxt_s = COLLECT;
          cnt_nxt_s   = 2'd0;
          data_nxt_s  = 32'h0000_0000;
          be_nxt_s    = 4'b0000;
`ifdef BYTE_PACKER_CHECKSUM_EN
          chk_nxt_s   = 8'h00;
`endif
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = COLLECT;
        cnt_nxt_s   = 2'd0;
        data_nxt_s  = 32'h0000_0000;
        be_nxt_s    = 4'b0000;
`ifdef BYTE_PACKER_CHECKSUM_EN
        chk_nxt_s   = 8'h00;
`endif
      end
    endcase
  end

  // State and word registers; reset discards any partial or held word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= COLLECT;
      cnt_r   <= 2'd0;
      data_r  <= 32'h0000_0000;
      be_r    <= 4'b0000;
`ifdef BYTE_PACKER_CHECKSUM_EN
      chk_r   <= 8'h00;
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
      be_r    <= be_nxt_s;
`ifdef BYTE_PACKER_CHECKSUM_EN
      chk_r   <= chk_nxt_s;
`endif
    end
  end

  assign data_o = data_r;
  assign be_o   = be_r;
`ifdef BYTE_PACKER_CHECKSUM_EN
  assign chk_o  = chk_r;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// Directed self-checking bench for byte_packer; checksum checks are active
// when BYTE_PACKER_CHECKSUM_EN is defined.
module tb_byte_packer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [3:0]  be_o;
`ifdef BYTE_PACKER_CHECKSUM_EN
  logic [7:0]  chk_o;
`endif

  int total = 0;
  int bad = 0;
  int words_taken = 0;
  int cycles = 0;
  int w0;
  int c0;

  byte_packer dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .be_o    (be_o)
`ifdef BYTE_PACKER_CHECKSUM_EN
    ,
    .chk_o   (chk_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cycles <= cycles + 1;
    if (valid_o && ready_i) words_taken <= words_taken + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_chk(input string tag, input logic [7:0] exp);
`ifdef BYTE_PACKER_CHECKSUM_EN
    check(tag, {24'h0, chk_o}, {24'h0, exp});
`endif
  endtask

  // Present a byte and hold it until the DUT accepts it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    valid_i = 1'b1;
    data_i  = b;
    n = 0;
    while (!ready_o && n < 16) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      total = total + 1;
      bad = bad + 1;
      $error("FAIL send_timeout observed=%h expected=%h", ready_o, 1'b1);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0; valid_i = 1'b0; data_i = 8'h00; flush_i = 1'b0; ready_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_be", {28'h0, be_o}, 32'h0);
    check_chk("rst_chk", 8'h00);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'h0, ready_o}, 32'h1);

    // Full word 11..44
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1_no_early_valid", {31'h0, valid_o}, 32'h0);
    send_byte(8'h44);
    check("t1_valid", {31'h0, valid_o}, 32'h1);
    check("t1_ready_low", {31'h0, ready_o}, 32'h0);
    check("t1_data", data_o, 32'h44332211);
    check("t1_be", {28'h0, be_o}, 32'hF);
    check_chk("t1_chk", 8'h44);
    @(posedge clk_i); @(negedge clk_i);
    check("t1_taken_valid", {31'h0, valid_o}, 32'h0);
    check("t1_taken_ready", {31'h0, ready_o}, 32'h1);
    check("t1_cleared_data", data_o, 32'h0);
    check("t1_cleared_be", {28'h0, be_o}, 32'h0);

    // Partial word AA,BB then flush
    send_byte(8'hAA); send_byte(8'hBB);
    check("t2_partial_data", data_o, 32'h0000BBAA);
    check("t2_no_valid", {31'h0, valid_o}, 32'h0);
    flush_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    flush_i = 1'b0;
    check("t2_valid", {31'h0, valid_o}, 32'h1);
    check("t2_data", data_o, 32'h0000BBAA);
    check("t2_be", {28'h0, be_o}, 32'h3);
    check_chk("t2_chk", 8'h11);
    @(posedge clk_i); @(negedge clk_i);

    // Byte with flush in same cycle at cnt 0
    flush_i = 1'b1;
    send_byte(8'hCC);
    flush_i = 1'b0;
    check("t3_valid", {31'h0, valid_o}, 32'h1);
    check("t3_data", data_o, 32'h000000CC);
    check("t3_be", {28'h0, be_o}, 32'h1);
    check_chk("t3_chk", 8'hCC);
    @(posedge clk_i); @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    flush_i = 1'b0;
    check("t3_empty_flush_valid", {31'h0, valid_o}, 32'h0);
    check("t3_empty_flush_ready", {31'h0, ready_o}, 32'h1);

    // Backpressure: hold word for 5 cycles, flush in HOLD is ignored
    ready_i = 1'b0;
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    for (int i = 0; i < 5; i++) begin
      flush_i = (i == 2);
      check("t4_hold_valid", {31'h0, valid_o}, 32'h1);
      check("t4_hold_ready", {31'h0, ready_o}, 32'h0);
      check("t4_hold_data", data_o, 32'h88776655);
      check("t4_hold_be", {28'h0, be_o}, 32'hF);
      @(posedge clk_i); @(negedge clk_i);
    end
    flush_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("t4_release_valid", {31'h0, valid_o}, 32'h0);
    check("t4_release_ready", {31'h0, ready_o}, 32'h1);
    @(posedge clk_i); @(negedge clk_i);
    check("t4_flush_forgotten", {31'h0, valid_o}, 32'h0);

    // Reset mid-word
    send_byte(8'hDE); send_byte(8'hAD);
    check("t5_partial", data_o, 32'h0000ADDE);
    rstn_i = 1'b0;
    #1;
    check("t5_rst_data", data_o, 32'h0);
    check("t5_rst_be", {28'h0, be_o}, 32'h0);
    check("t5_rst_valid", {31'h0, valid_o}, 32'h0);
    check_chk("t5_rst_chk", 8'h00);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("t5_ready", {31'h0, ready_o}, 32'h1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("t5_data", data_o, 32'h04030201);
    check("t5_be", {28'h0, be_o}, 32'hF);
    check_chk("t5_chk", 8'h04);
    @(posedge clk_i); @(negedge clk_i);

    // Back-to-back stream of 8 bytes
    w0 = words_taken;
    c0 = cycles;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("t6_word0", data_o, 32'h03020100);
    check("t6_word0_valid", {31'h0, valid_o}, 32'h1);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    check("t6_word1", data_o, 32'h07060504);
    check("t6_word1_valid", {31'h0, valid_o}, 32'h1);
    check("t6_cycles", cycles - c0, 32'd9);
    @(posedge clk_i); @(negedge clk_i);
    check("t6_words", words_taken - w0, 32'd2);
    check("t6_idle", {31'h0, valid_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port valid_i, input, 1 bit: upstream byte valid (fed by the 8-bit FIFO's valid_o).
REQ-004 SHALL have port ready_o, output, 1 bit: byte accepted when valid_i & ready_o (drives the FIFO's ready_i).
REQ-005 SHALL have port data_i, input, 8 bits: upstream byte.
REQ-006 SHALL have port flush_i, input, 1 bit: emit the partially filled word.
REQ-007 SHALL have port valid_o, output, 1 bit: packed word valid.
REQ-008 SHALL have port ready_i, input, 1 bit: downstream accepts the word when valid_o & ready_i.
REQ-009 SHALL have port data_o, output, 32 bits: packed word, first byte in [7:0].
REQ-010 SHALL have port be_o, output, 4 bits: byte enables; bit n set when byte n of data_o is valid.
REQ-011 SHALL have port chk_o, output, 8 bits: XOR checksum of the enabled bytes; present only with BYTE_PACKER_CHECKSUM_EN.

Function
REQ-012 SHALL implement two states: COLLECT (ready_o=1, valid_o=0) and HOLD (ready_o=0, valid_o=1).
REQ-013 SHALL, in COLLECT, on an accepted byte, write data_i into lane cnt, set be_o[cnt], and increment the 2-bit counter cnt.
REQ-014 SHALL go COLLECT->HOLD in the cycle the fourth byte is accepted (cnt==3), with be_o=4'b1111 and valid_o asserted the next cycle.
REQ-015 SHALL go COLLECT->HOLD on flush_i=1 when cnt>0 or a byte is accepted that cycle; the same-cycle byte is included in the word.
REQ-016 SHALL ignore flush_i when cnt==0 and no byte is accepted, and SHALL ignore flush_i in HOLD (not remembered).
REQ-017 SHALL hold data_o, be_o and chk_o stable while valid_o=1 and ready_i=0.
REQ-018 SHALL go HOLD->COLLECT on valid_o & ready_i, clearing cnt, be_o and lanes to 0; ready_o rises the following cycle (no same-cycle accept).
REQ-019 SHALL keep unwritten lanes of a partial word at 8'h00.
REQ-020 SHALL have a latency of exactly 1 cycle from acceptance of the last byte (or flush) to valid_o=1.
REQ-021 SHALL wrap cnt from 3 to 0 only via HOLD; no byte is ever overwritten or dropped.
REQ-022 SHALL have a sustained throughput of 4 bytes per 5 cycles when ready_i=1 is held.

Reset
REQ-023 SHALL, while rstn_i=0, force state=COLLECT, cnt=0, data_o=0, be_o=0, chk_o=0 and valid_o=0, with ready_o=1 once rstn_i deasserts.
REQ-024 SHALL discard any partial or held word on reset asserted mid-operation.

Configuration
REQ-025 SHALL, with macro BYTE_PACKER_CHECKSUM_EN defined, provide chk_o as a running XOR updated on each accepted byte, cleared with be_o and registered alongside data_o.
REQ-026 SHALL, without BYTE_PACKER_CHECKSUM_EN, omit the chk_o port and its logic entirely, leaving all other behaviour unchanged.

Structure
REQ-027 SHALL place the state enum (COLLECT, HOLD) and the constant WORD_BYTES=4 in the shared package byte_packer_pkg.
REQ-028 SHALL be a single flat module with no sub-module; the checksum is inline logic.

Verification
REQ-029 SHALL cover: bytes 11,22,33,44 with ready_i=1 -> data_o=32'h44332211, be_o=4'hF, chk_o=8'h44, valid_o 1 cycle after the 4th byte.
REQ-030 SHALL cover: bytes AA,BB then flush_i pulse -> data_o=32'h0000BBAA, be_o=4'h3, chk_o=8'h11.
REQ-031 SHALL cover: byte CC with flush_i in the same cycle at cnt=0 -> data_o=32'h000000CC, be_o=4'h1; flush_i at cnt=0 without a byte -> no valid_o.
REQ-032 SHALL cover: full word with ready_i=0 for 5 cycles -> valid_o=1, ready_o=0, and data_o stable throughout; the word is taken on ready_i=1 and ready_o=1 the next cycle.
REQ-033 SHALL cover: rstn_i pulsed low after 2 bytes -> all outputs 0, then bytes 01..04 -> data_o=32'h04030201.
REQ-034 SHALL cover: back-to-back feed from the fifo of 8 bytes 00..07 -> two words 32'h03020100 and 32'h07060504, no loss or duplication.
